change_dispenser: RTL and testbench

//   Payout side of the coin vending path. The coin-accept FSM accumulates nickel/dime credit; this block

---
 rtl/vending_pkg.sv | 26 ++
 rtl/change_dispenser_if.sv | 24 ++
 rtl/change_dispenser.sv | 110 +++++++++++
 tb/tb_change_dispenser.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// Shared definitions for the coin vending path (accept FSM and change dispenser).
// State encodings, coin values in nickel units and the default item price.
package vending_pkg;

   // Dispenser state encodings; IDLE must stay all-zero
   localparam logic [2:0] StIdle   = 3'b000;
   localparam logic [2:0] StVend   = 3'b001;
   localparam logic [2:0] StSelect = 3'b010;
   localparam logic [2:0] StReq    = 3'b011;
   localparam logic [2:0] StRel    = 3'b100;
   localparam logic [2:0] StDone   = 3'b101;

   // Coin values in nickel units
   localparam int unsigned NICKEL_VAL = 1;
   localparam int unsigned DIME_VAL   = 2;

   // Default counter width and item price (3 nickels = 15c)
   localparam int unsigned DEFAULT_CW    = 4;
   localparam int unsigned DEFAULT_PRICE = 3;

   // Value of one ejected coin in nickel units
   function automatic int unsigned coin_value(input logic is_dime);
      return is_dime ? DIME_VAL : NICKEL_VAL;
   endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Handshake bundle between the accept FSM / coin hopper side and the change dispenser.
// master: drives Start/Credit and the hopper Ack; slave: the dispenser itself.
interface change_dispenser_if #(
   parameter int unsigned CW = 4
);
   logic          start;
   logic [CW-1:0] credit;
   logic          ack;
   logic          nickel_out;
   logic          dime_out;
   logic          vend;
   logic          busy;
   logic          done;

   modport master (
      output start, credit, ack,
      input  nickel_out, dime_out, vend, busy, done
   );

   modport slave (
      input  start, credit, ack,
      output nickel_out, dime_out, vend, busy, done
   );
endinterface

// File: rtl/change_dispenser.sv
// Change dispenser: captures credit, pulses Vend when credit covers PRICE, then pays the
// change (or refunds the whole credit) one coin at a time over a four-phase req/ack handshake.
// Build option: define CHANGE_DIME_EN for greedy dime-first change; otherwise nickels only.
module change_dispenser
   import vending_pkg::*;
#(
   parameter int unsigned CW    = DEFAULT_CW,
   parameter int unsigned PRICE = DEFAULT_PRICE
) (
   input logic               clk_i,
   input logic               rst_ni,
   change_dispenser_if.slave pay
);

   localparam logic [CW-1:0] PriceW  = CW'(PRICE);
   localparam logic [CW-1:0] DimeW   = CW'(DIME_VAL);

   logic [2:0]    state_q, state_d;
   logic [CW-1:0] remaining_q, remaining_d;
   logic          vend_ok_q, vend_ok_d;
   logic          coin_dime_q, coin_dime_d;
   logic          pick_dime;

`ifdef CHANGE_DIME_EN
   // Greedy: a dime only when it cannot underflow the remaining change
   assign pick_dime = (remaining_q >= DimeW);
`else
   assign pick_dime = 1'b0;
`endif

   // State, remaining change and coin choice registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         remaining_q <= '0;
         vend_ok_q   <= 1'b0;
         coin_dime_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         vend_ok_q   <= vend_ok_d;
         coin_dime_q <= coin_dime_d;
      end
   end

   // Next-state and counter update
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      vend_ok_d   = vend_ok_q;
      coin_dime_d = coin_dime_q;
      case (state_q)
         StIdle: begin
            if (pay.start) begin
               if (pay.credit >= PriceW) begin
                  remaining_d = pay.credit - PriceW;
                  vend_ok_d   = 1'b1;
               end else begin
                  remaining_d = pay.credit;
                  vend_ok_d   = 1'b0;
               end
               state_d = StVend;
            end
         end
         StVend: state_d = StSelect;
         StSelect: begin
            if (remaining_q == '0) begin
               state_d = StDone;
            end else begin
               coin_dime_d = pick_dime;
               state_d     = StReq;
            end
         end
         StReq: begin
            // Ack already high on entry counts for this coin
            if (pay.ack) begin
               remaining_d = remaining_q - CW'(coin_value(coin_dime_q));
               state_d     = StRel;
            end
         end
         StRel: begin
            if (!pay.ack) state_d = StSelect;
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   logic nickel_o, dime_o, vend_o, busy_o, done_o;

   // Moore output decode from registered state only
   always_comb begin
      nickel_o = (state_q == StReq) && !coin_dime_q;
`ifdef CHANGE_DIME_EN
      dime_o   = (state_q == StReq) && coin_dime_q;
`else
      dime_o   = 1'b0;
`endif
      vend_o   = (state_q == StVend) && vend_ok_q;
      busy_o   = (state_q != StIdle);
      done_o   = (state_q == StDone);
   end

   assign pay.nickel_out = nickel_o;
   assign pay.dime_out   = dime_o;
   assign pay.vend       = vend_o;
   assign pay.busy       = busy_o;
   assign pay.done       = done_o;

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized self-checking bench for change_dispenser against a coin-count reference model.
// Honours CHANGE_DIME_EN the same way the design does.
module tb_change_dispenser;
   import vending_pkg::*;

   localparam int unsigned CW    = 4;
   localparam int unsigned PRICE = 3;
`ifdef CHANGE_DIME_EN
   localparam bit DimeEn = 1'b1;
`else
   localparam bit DimeEn = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   change_dispenser_if #(.CW(CW)) bus ();

   change_dispenser #(.CW(CW), .PRICE(PRICE)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .pay    (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Observed-event counters, sampled on the falling edge
   int   vend_cnt, nick_cnt, dime_cnt, both_cnt;
   logic nick_prev = 1'b0, dime_prev = 1'b0;
   always @(negedge clk) begin
      if (bus.vend === 1'b1) vend_cnt++;
      if (bus.nickel_out === 1'b1 && !nick_prev) nick_cnt++;
      if (bus.dime_out === 1'b1 && !dime_prev) dime_cnt++;
      if (bus.nickel_out === 1'b1 && bus.dime_out === 1'b1) both_cnt++;
      nick_prev = (bus.nickel_out === 1'b1);
      dime_prev = (bus.dime_out === 1'b1);
   end

   // Reference: what a payout of this credit should look like
   task automatic model(input int credit, output int vend, output int dimes, output int nickels);
      int change;
      vend   = (credit >= int'(PRICE)) ? 1 : 0;
      change = vend ? credit - int'(PRICE) : credit;
      if (DimeEn) begin
         dimes   = change / 2;
         nickels = change % 2;
      end else begin
         dimes   = 0;
         nickels = change;
      end
   endtask

   task automatic run_payout(input int credit, input bit disturb);
      int ev, ed, en, kind, waitc, hold;
      model(credit, ev, ed, en);
      @(negedge clk);
      vend_cnt = 0; nick_cnt = 0; dime_cnt = 0; both_cnt = 0;
      bus.start  = 1'b1;
      bus.credit = CW'(credit);
      @(negedge clk);
      bus.start  = 1'b0;
      bus.credit = CW'($urandom);
      check_eq("vend_at_plus1", int'(bus.vend), ev);
      check_eq("busy_at_plus1", int'(bus.busy), 1);
      if (ed + en == 0) begin
         @(negedge clk);
         check_eq("busy_at_plus2", int'(bus.busy), 1);
         check_eq("no_done_at_plus2", int'(bus.done), 0);
         @(negedge clk);
         check_eq("done_at_plus3", int'(bus.done), 1);
      end else begin
         for (int i = 0; i < ed + en; i++) begin
            kind  = (i < ed) ? 1 : 0;
            waitc = 0;
            while (!(bus.nickel_out || bus.dime_out) && waitc < 20) begin
               @(negedge clk);
               waitc++;
            end
            if (waitc >= 20) begin
               check_eq("req_timeout", 0, 1);
               return;
            end
            check_eq("coin_kind", int'(bus.dime_out), kind);
            hold = $urandom_range(0, 3);
            for (int h = 0; h < hold; h++) begin
               @(negedge clk);
               if (disturb) begin
                  bus.start  = 1'(($urandom));
                  bus.credit = CW'($urandom);
               end
            end
            check_eq("req_held", int'(bus.nickel_out || bus.dime_out), 1);
            bus.ack = 1'b1;
            waitc   = 0;
            @(negedge clk);
            while ((bus.nickel_out || bus.dime_out) && waitc < 20) begin
               @(negedge clk);
               waitc++;
            end
            check_eq("req_dropped", int'(bus.nickel_out || bus.dime_out), 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            bus.ack   = 1'b0;
            bus.start = 1'b0;
         end
         waitc = 0;
         while (!bus.done && waitc < 20) begin
            @(negedge clk);
            waitc++;
         end
         check_eq("done_seen", int'(bus.done), 1);
      end
      @(negedge clk);
      check_eq("done_one_cycle", int'(bus.done), 0);
      check_eq("idle_not_busy", int'(bus.busy), 0);
      check_eq("vend_count", vend_cnt, ev);
      check_eq("dime_count", dime_cnt, ed);
      check_eq("nickel_count", nick_cnt, en);
      check_eq("never_both", both_cnt, 0);
   endtask

   task automatic reset_mid_payout();
      int waitc;
      @(negedge clk);
      bus.start  = 1'b1;
      bus.credit = CW'(5);
      @(negedge clk);
      bus.start = 1'b0;
      waitc = 0;
      while (!(bus.nickel_out || bus.dime_out) && waitc < 20) begin
         @(negedge clk);
         waitc++;
      end
      check_eq("rst_pre_req", int'(bus.nickel_out || bus.dime_out), 1);
      check_eq("rst_pre_kind", int'(bus.dime_out), DimeEn ? 1 : 0);
      #2 rst_n = 1'b0;
      #1;
      check_eq("rst_async_nickel", int'(bus.nickel_out), 0);
      check_eq("rst_async_dime", int'(bus.dime_out), 0);
      check_eq("rst_async_busy", int'(bus.busy), 0);
      check_eq("rst_async_vend", int'(bus.vend), 0);
      check_eq("rst_async_done", int'(bus.done), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("rst_release_idle", int'(bus.busy), 0);
   endtask

   initial begin
      rst_n      = 1'b0;
      bus.start  = 1'b0;
      bus.credit = '0;
      bus.ack    = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("reset_busy", int'(bus.busy), 0);
      check_eq("reset_vend", int'(bus.vend), 0);
      check_eq("reset_done", int'(bus.done), 0);
      check_eq("reset_nickel", int'(bus.nickel_out), 0);
      check_eq("reset_dime", int'(bus.dime_out), 0);
      rst_n = 1'b1;

      run_payout(3, 1'b0);
      run_payout(4, 1'b0);
      run_payout(7, 1'b0);
      run_payout(2, 1'b0);
      run_payout(0, 1'b0);
      run_payout(15, 1'b1);
      run_payout(9, 1'b1);

      reset_mid_payout();
      run_payout(3, 1'b0);

      for (int t = 0; t < 30; t++) begin
         run_payout(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
